image_load_block: RTL
=====================

// Module: image_load_block
// PURPOSE
// Upstream fetch stage for pool_layer (and conv layers): on a load request, reads a
// size*size image from on-chip feature RAM, one word per cycle, into a 1024-entry buffer.
// Presents the buffer as a parallel array output and raises done.
// Handshake matches pool_layer's loadEnable/loadAddr/loadSize/loadOut/loadDone.
// PARAMETERS
// DATA_SZ    16    word width of RAM data and buffer entries
// ADDR_SZ    16    RAM address width
// BUF_DEPTH  1024  buffer entries; maximum words per load
// PORTS
// clk        in   1                   clock, all logic on posedge
// reset      in   1                   synchronous, active-high
// enable     in   1                   load request (level); driven by the consumer's loadEnable
// addr       in   ADDR_SZ             image base address; sampled when a request is accepted
// size       in   DATA_SZ             image side length; load count N = size*size
// ramAddr    out  ADDR_SZ             RAM read address
// ramReadEn  out  1                   RAM read strobe
// ramData    in   DATA_SZ (signed)    RAM read data; valid the cycle after ramReadEn
// dataOut    out  DATA_SZ x BUF_DEPTH signed buffer, index 0 = word at addr
// done       out  1                   load complete; drives consumer's loadDone
// BEHAVIOUR
// - Reset: state=IDLE, done=0, ramReadEn=0, ramAddr=0, counters=0, every dataOut entry=0.
//   Reset wins over all other inputs, including mid-load.
// - FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
// - IDLE: enable=1 at edge T: latch base=addr, N=size*size (32-bit product).
//   If N>BUF_DEPTH, N=BUF_DEPTH. If N==0, go straight to DONE (no RAM reads).
// - READ: ramReadEn=1, ramAddr=base+i for i=0..N-1 in cycles T+1..T+N.
//   Address adds modulo 2^ADDR_SZ, wrapping from 0xFFFF to 0x0000.
//   After the read with i=N-1, go to DRAIN.
// - Capture: ramData valid in cycle T+1+i+1 is written to dataOut[i] at the end of that cycle.
//   The write pipeline index is a registered copy of i.
// - DRAIN: one cycle; ramReadEn=0; captures the last word (i=N-1). Then go to DONE.
// - DONE: done=1, first visible in cycle T+N+2, so latency is N+2 cycles from request
//   sampling to done. done stays high and dataOut stays stable while enable=1.
//   When enable=0 is sampled, done clears on the next edge and the FSM returns to IDLE.
// - A new request needs enable low for at least one sampled cycle after done.
//   enable held high across DONE never retriggers a load.
// - Abort: enable=0 sampled in READ or DRAIN -> IDLE next edge.
//   ramReadEn=0, done stays 0; any read already in flight is still written to the buffer.
//   Entries not yet written keep their previous values.
// - Entries at index >= N keep their previous contents; they are not cleared per load.
// - addr and size changes after acceptance are ignored until the next IDLE acceptance.
// - ramAddr holds its last value when ramReadEn=0.
// TESTING
// 1 Reset: assert reset mid-READ (size=4) -> next cycle ramReadEn=0, done=0, all dataOut=0.
// 2 Basic: RAM[i]=100+i, addr=0x0010, size=3, enable held high.
//   -> reads at 0x10..0x18 in cycles T+1..T+9, done=1 at T+11, dataOut[0..8]=100..108.
// 3 Wrap/clamp: addr=0xFFFE, size=2 -> reads 0xFFFE,0xFFFF,0x0000,0x0001.
//   size=40 -> exactly 1024 reads, done at T+1026.
// 4 Zero: size=0 -> no ramReadEn pulse, done=1 at T+1, dataOut unchanged.
// 5 Handshake: enable kept high after done -> done stays 1, no new reads.
//   Drop enable one cycle, then reassert with addr=0x0100 -> done clears, second load runs.
// 6 Abort: size=4, deassert enable at T+2 -> no reads after T+2, done never rises.
//   dataOut[0] updated, dataOut[2..3] unchanged.

Source files
------------

// File: rtl/image_load_block.sv
// ---------------------------------------------------------------------------
// image_load_block
//
// Fetch stage that feeds pool/conv layers. When a load is requested, it reads a
// size*size image from feature RAM, starting at addr, one word per cycle. The
// words go into a buffer of BUF_DEPTH entries. The buffer is exposed as a
// parallel array, and done is raised once the last word has landed.
//
// Ports
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-high; wins over every other input
//   enable     in   load request (level), consumer's loadEnable
//   addr       in   image base address, sampled on request acceptance
//   size       in   image side length; load count N = min(size*size, BUF_DEPTH)
//   ramAddr    out  RAM read address (holds last value while not reading)
//   ramReadEn  out  RAM read strobe
//   ramData    in   RAM read data, valid the cycle after ramReadEn
//   dataOut    out  buffer contents, index 0 = word at addr
//   done       out  load complete, consumer's loadDone
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for enable; accepting a request latches addr and N
// READ  | one RAM read per cycle, ramAddr = base+i, i = 0..N-1
// DRAIN | no read; the last word (i = N-1) is written into the buffer
// DONE  | done = 1, buffer stable; leaves only once enable is seen low
// ---------------------------------------------------------------------------
module image_load_block #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int BUF_DEPTH = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ADDR_SZ-1:0]        addr,
  input  logic [DATA_SZ-1:0]        size,
  output logic [ADDR_SZ-1:0]        ramAddr,
  output logic                      ramReadEn,
  input  logic signed [DATA_SZ-1:0] ramData,
  output logic signed [DATA_SZ-1:0] dataOut [BUF_DEPTH],
  output logic                      done
);

  localparam int IDX_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int PROD_W = 2 * DATA_SZ;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Load count decode on the live size input. These values are only
  // meaningful in the IDLE acceptance cycle.
  logic [PROD_W-1:0] load_prod;
  logic              load_zero;
  logic [IDX_W-1:0]  load_last;

  // Read side: the down-counter reaches terminal count on the final read.
  // rd_idx is the buffer index of the read that is on the bus now.
  logic [IDX_W-1:0]  rd_left;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_last;

  // Write side: this is the read side delayed by one cycle, to match the
  // RAM read latency.
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  always_comb begin
    load_prod = {{DATA_SZ{1'b0}}, size} * {{DATA_SZ{1'b0}}, size};
    load_zero = (load_prod == '0);
    if (load_prod > PROD_W'(BUF_DEPTH)) begin
      load_last = IDX_W'(BUF_DEPTH - 1);
    end else begin
      load_last = IDX_W'(load_prod - PROD_W'(1));
    end
  end

  assign rd_last = (rd_left == '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = load_zero ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // An abort takes priority over finishing the read sequence.
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (rd_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_nxt = enable ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        // A request held high across DONE must never restart a load,
        // so the only way out of DONE is a sampled low.
        if (!enable) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    ramReadEn = 1'b0;
    done      = 1'b0;
    case (state)
      S_READ:  ramReadEn = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read address and counters
  // ramAddr is the base+i register. It is loaded on acceptance and advanced
  // on every non-final read. It is never advanced past the last issued read,
  // so it keeps the last address while the strobe is low. A zero-length load
  // issues no read, so it leaves ramAddr untouched.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ramAddr <= '0;
      rd_left <= '0;
      rd_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && !load_zero) begin
            ramAddr <= addr;
            rd_left <= load_last;
            rd_idx  <= '0;
          end
        end
        S_READ: begin
          if (enable && !rd_last) begin
            ramAddr <= ramAddr + ADDR_SZ'(1);
            rd_left <= rd_left - IDX_W'(1);
            rd_idx  <= rd_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write pipeline
  // This pipeline follows the strobe regardless of state. A read that is
  // already issued when an abort happens therefore still lands in the
  // buffer.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en  <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_en  <= ramReadEn;
      wr_idx <= rd_idx;
    end
  end

  // ---------------------------------------------------------------------
  // Buffer
  // Entries are cleared only by reset. Entries a load does not reach keep
  // whatever the earlier loads left in them.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BUF_DEPTH; k++) begin
        dataOut[k] <= '0;
      end
    end else if (wr_en) begin
      dataOut[wr_idx] <= ramData;
    end
  end

endmodule
